pio_param_loader: RTL and testbench

PIO_PARAM_LOADER -- requirements
Module: pio_param_loader

---
 rtl/pio_param_loader.sv | 144 ++++++++++++++
 tb/tb_pio_param_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pio_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : pio_param_loader
// Description : HPS-to-fabric parameter loader. A four-phase PIO handshake
//               writes a 31 x 32-bit register file; index 31 is a command
//               register (bit0 = go, bit1 = clear all).
//               Optional registered readback on rb_data when the macro
//               PARAM_LOADER_READBACK_EN is defined; otherwise rb_data = 0.
// Revision    : 1.0 - initial release
// ============================================================================
module pio_param_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic        wr_req,
    output logic        wr_ack,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic        upd_pulse,
    output logic [4:0]  upd_addr,
    output logic        go_pulse,
    output logic [31:0] rb_data
);

    localparam logic [4:0] c_CMD_ADDR    = 5'd31;
    localparam int         c_NUM_ENTRIES = 31;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WRITE  = 2'd1,
        S_ACK_HI = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_req_s1;
    logic        r_req_s;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic [31:0] r_regs [0:c_NUM_ENTRIES-1];
    logic        r_wr_ack;
    logic        r_upd_pulse;
    logic [4:0]  r_upd_addr;
    logic        r_go_pulse;

    // wr_req comes straight from an HPS PIO, so it is resynchronised first.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req_s1 <= 1'b0;
            r_req_s  <= 1'b0;
        end else begin
            r_req_s1 <= wr_req;
            r_req_s  <= r_req_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= 5'd0;
            r_data      <= 32'd0;
            r_wr_ack    <= 1'b0;
            r_upd_pulse <= 1'b0;
            r_upd_addr  <= 5'd0;
            r_go_pulse  <= 1'b0;
            for (int i = 0; i < c_NUM_ENTRIES; i++) begin
                r_regs[i] <= 32'd0;
            end
        end else begin
            r_upd_pulse <= 1'b0;
            r_go_pulse  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Address and data are captured only here, so HPS-side
                    // changes during the handshake cannot corrupt a write.
                    if (r_req_s) begin
                        r_addr  <= wr_addr;
                        r_data  <= wr_data;
                        r_state <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wr_ack <= 1'b1;
                    r_state  <= S_ACK_HI;
                    if (r_addr == c_CMD_ADDR) begin
                        if (r_data[1]) begin
                            for (int i = 0; i < c_NUM_ENTRIES; i++) begin
                                r_regs[i] <= 32'd0;
                            end
                        end
                        r_go_pulse <= r_data[0];
                    end else begin
                        r_regs[r_addr] <= r_data;
                        r_upd_pulse    <= 1'b1;
                        r_upd_addr     <= r_addr;
                    end
                end
                S_ACK_HI: begin
                    // Returning to IDLE only after req_s is low forces a fresh
                    // low-then-high request for the next write.
                    if (!r_req_s) begin
                        r_wr_ack <= 1'b0;
                        r_state  <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        rd_data = 32'd0;
        if (rd_addr != c_CMD_ADDR) begin
            rd_data = r_regs[rd_addr];
        end
    end

`ifdef PARAM_LOADER_READBACK_EN
    logic [31:0] r_rb_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rb_data <= 32'd0;
        end else if (wr_addr == c_CMD_ADDR) begin
            r_rb_data <= 32'd0;
        end else begin
            r_rb_data <= r_regs[wr_addr];
        end
    end

    assign rb_data = r_rb_data;
`else
    assign rb_data = 32'd0;
`endif

    assign wr_ack    = r_wr_ack;
    assign upd_pulse = r_upd_pulse;
    assign upd_addr  = r_upd_addr;
    assign go_pulse  = r_go_pulse;

endmodule
`default_nettype wire

// File: tb/tb_pio_param_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_pio_param_loader
// Description : Self-checking bench for pio_param_loader; expected register
//               updates are queued at stimulus time and popped on upd_pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pio_param_loader;

    logic        clk;
    logic        reset;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_req;
    logic        wr_ack;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        upd_pulse;
    logic [4:0]  upd_addr;
    logic        go_pulse;
    logic [31:0] rb_data;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model [0:31];
    int          go_count;
    int          checks;
    int          errors;

    pio_param_loader dut (
        .clk       (clk),
        .reset     (reset),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_req    (wr_req),
        .wr_ack    (wr_ack),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .upd_pulse (upd_pulse),
        .upd_addr  (upd_addr),
        .go_pulse  (go_pulse),
        .rb_data   (rb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every upd_pulse cycle must match the oldest queued write.
    always @(negedge clk) begin
        if (upd_pulse === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL upd_unexpected: upd_pulse=1 upd_addr=%0d, required no pulse", upd_addr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (upd_addr !== e.a) begin
                    errors++;
                    $display("FAIL upd_addr: got %0d, required %0d", upd_addr, e.a);
                end
            end
        end
        if (go_pulse === 1'b1) go_count++;
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            input int hold, input logic [31:0] scramble);
        int cnt;
        int g0;
        g0 = go_count;
        @(negedge clk);
        wr_addr = a;
        wr_data = d;
        wr_req  = 1'b1;
        if (a != 5'd31) exp_q.push_back('{a: a, d: d});
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (wr_ack !== 1'b1 && cnt < 20);
        checks++;
        if (cnt != 4 || wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL ack_rise: addr=%0d edges=%0d ack=%b, required 4 edges ack=1", a, cnt, wr_ack);
        end
        if (a != 5'd31) model[a] = d;
        else if (d[1]) model_clear();
        wr_data = scramble;
        wr_addr = a ^ 5'd1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            checks++;
            if (wr_ack !== 1'b1) begin
                errors++;
                $display("FAIL ack_hold: cycle %0d ack=%b, required 1", k, wr_ack);
            end
        end
        wr_req = 1'b0;
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (wr_ack !== 1'b0 && cnt < 20);
        checks++;
        if (cnt != 3 || wr_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_fall: edges=%0d ack=%b, required 3 edges ack=0", cnt, wr_ack);
        end
        if (a == 5'd31) begin
            checks++;
            if ((go_count - g0) != int'(d[0])) begin
                errors++;
                $display("FAIL go_count: got %0d pulses, required %0d", go_count - g0, d[0]);
            end
        end
    endtask

    task automatic check_entries(input string tag);
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            checks++;
            if (rd_data !== model[i]) begin
                errors++;
                $display("FAIL %s_rd[%0d]: got %h, required %h", tag, i, rd_data, model[i]);
            end
        end
    endtask

    task automatic test_reset();
        reset   = 1'b1;
        wr_req  = 1'b0;
        wr_addr = 5'd0;
        wr_data = 32'd0;
        rd_addr = 5'd0;
        repeat (3) @(negedge clk);
        checks++;
        if ({wr_ack, upd_pulse, go_pulse} !== 3'b000 || upd_addr !== 5'd0 || rb_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b upd=%b go=%b upd_addr=%0d rb=%h, required all 0",
                     wr_ack, upd_pulse, go_pulse, upd_addr, rb_data);
        end
        reset = 1'b0;
        model_clear();
        check_entries("reset");
    endtask

    task automatic test_basic_write();
        do_write(5'd2, 32'h0001C000, 4, 32'hDEADBEEF);
        rd_addr = 5'd2;
        @(negedge clk);
        checks++;
        if (rd_data !== 32'h0001C000 || upd_addr !== 5'd2) begin
            errors++;
            $display("FAIL basic_write: rd=%h upd_addr=%0d, required 0001c000 and 2", rd_data, upd_addr);
        end
    endtask

    task automatic test_random_writes();
        for (int n = 0; n < 8; n++) begin
            do_write(5'($urandom_range(0, 30)), $urandom, n % 3, $urandom);
        end
        do_write(5'd0, 32'hFFFFFFFF, 0, 32'd0);
        do_write(5'd30, 32'h80000001, 1, 32'd0);
        check_entries("random");
    endtask

    task automatic test_commands();
        do_write(5'd31, 32'h00000001, 0, 32'd0);
        check_entries("go_only");
        do_write(5'd31, 32'hFFFFFFF4, 0, 32'd0);
        check_entries("ignored_bits");
        do_write(5'd31, 32'h00000003, 2, 32'd0);
        check_entries("clear_go");
        do_write(5'd11, 32'h0BADF00D, 0, 32'd0);
        do_write(5'd31, 32'h00000002, 0, 32'd0);
        check_entries("clear_only");
    endtask

    task automatic test_reset_mid_write();
        int cnt;
        do_write(5'd7, 32'h11112222, 0, 32'd0);
        @(negedge clk);
        wr_addr = 5'd7;
        wr_data = 32'hCAFEF00D;
        wr_req  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        rd_addr = 5'd7;
        #1;
        checks++;
        if (wr_ack !== 1'b0 || rd_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_abort: ack=%b rd=%h, required ack=0 rd=0", wr_ack, rd_data);
        end
        exp_q.push_back('{a: 5'd7, d: 32'hCAFEF00D});
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (wr_ack !== 1'b1 && cnt < 20);
        checks++;
        if (cnt != 4 || wr_ack !== 1'b1) begin
            errors++;
            $display("FAIL resume_ack: edges=%0d ack=%b, required 4 edges ack=1", cnt, wr_ack);
        end
        model[7] = 32'hCAFEF00D;
        wr_req = 1'b0;
        repeat (4) @(negedge clk);
        check_entries("resume");
    endtask

    task automatic test_readback();
        do_write(5'd5, 32'h12345678, 0, 32'd0);
        @(negedge clk);
        wr_addr = 5'd5;
        @(negedge clk);
`ifdef PARAM_LOADER_READBACK_EN
        checks++;
        if (rb_data !== 32'h12345678) begin
            errors++;
            $display("FAIL readback_5: got %h, required 12345678", rb_data);
        end
        wr_addr = 5'd31;
        @(negedge clk);
        checks++;
        if (rb_data !== 32'd0) begin
            errors++;
            $display("FAIL readback_31: got %h, required 0", rb_data);
        end
        wr_addr = 5'd7;
        @(negedge clk);
        checks++;
        if (rb_data !== model[7]) begin
            errors++;
            $display("FAIL readback_7: got %h, required %h", rb_data, model[7]);
        end
`else
        for (int k = 0; k < 3; k++) begin
            wr_addr = 5'(5 + k);
            @(negedge clk);
            checks++;
            if (rb_data !== 32'd0) begin
                errors++;
                $display("FAIL readback_off: got %h, required 0", rb_data);
            end
        end
`endif
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        go_count = 0;
        test_reset();
        test_basic_write();
        test_random_writes();
        test_commands();
        test_reset_mid_write();
        test_readback();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d writes never pulsed, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
